// File: rtl/afp_pkg.sv
// Shared definitions for the small-float multiplier: default field widths,
// exponent bias helper and the unpacked operand used by every lane.
package afp_pkg;

  localparam int AFP_EXP_W = 2;
  localparam int AFP_MAN_W = 1;
  localparam int AFP_W     = 1 + AFP_EXP_W + AFP_MAN_W;

  function automatic int afp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  localparam int AFP_BIAS = afp_bias(AFP_EXP_W);

  // exp is the unbiased exponent; man carries the hidden bit at its MSB.
  typedef struct packed {
    logic                        sign;
    logic signed [AFP_EXP_W+1:0] exp;
    logic        [AFP_MAN_W:0]   man;
  } afp_operand_t;

  // Subnormals share the exponent of the smallest normal, with hidden bit 0.
  function automatic afp_operand_t afp_unpack(input logic [AFP_W-1:0] v);
    afp_operand_t           u;
    logic [AFP_EXP_W-1:0]   e;
    e      = v[AFP_W-2 -: AFP_EXP_W];
    u.sign = v[AFP_W-1];
    u.man  = {e != '0, v[AFP_MAN_W-1:0]};
    u.exp  = $signed({2'b00, (e == '0) ? AFP_EXP_W'(1) : e}) - (AFP_EXP_W+2)'(AFP_BIAS);
    return u;
  endfunction

endpackage

// File: rtl/afp_mul_lane.sv
// One multiply lane: S1 exact product, S2 normalize/denormalize with sticky,
// S3 round-to-nearest-even, saturate and pack. Stage loads come from the top.
module afp_mul_lane
  import afp_pkg::*;
#(
  parameter int  EXP_W = AFP_EXP_W,
  parameter int  MAN_W = AFP_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld1,
  input  logic         ld2,
  input  logic         ld3,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic         unf
);

  localparam int BIAS = afp_bias(EXP_W);
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int FW   = PW + 2;
  localparam int LW   = $clog2(FW);
  localparam int XW   = EXP_W + 3 + $clog2(FW);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  afp_operand_t ua, ub;

  logic                    sign1_q, sign1_d;
  logic [PW-1:0]           prod1_q, prod1_d;
  logic signed [EXP_W+1:0] exp1_q, exp1_d;

  logic                    sign2_q, sign2_d;
  logic                    zero2_q, zero2_d;
  logic [XW-1:0]           f2_q, f2_d;
  logic [MAN_W:0]          kept2_q, kept2_d;
  logic                    guard2_q, guard2_d;
  logic                    sticky2_q, sticky2_d;

  logic [W-1:0]            res3_q, res3_d;
  logic                    ovf3_q, ovf3_d;
  logic                    unf3_q, unf3_d;

  // S1: exact significand product and biased exponent of a 1x.f-scaled result
  always_comb begin
    ua = afp_unpack(a);
    ub = afp_unpack(b);
    // NOTE: every always_comb output gets its hold value first so no path infers a latch.
    sign1_d = sign1_q;
    prod1_d = prod1_q;
    exp1_d  = exp1_q;
    if (ld1) begin
      sign1_d = ua.sign ^ ub.sign;
      prod1_d = PW'(ua.man) * PW'(ub.man);
      exp1_d  = ua.exp + ub.exp + (EXP_W+2)'(BIAS);
    end
  end

  logic [LW-1:0]     lz;
  logic [XW-1:0]     en, sh;
  logic [FW-1:0]     nfr;
  logic [2*FW-1:0]   wide;
  logic              sh_stk;

  // S2: bring the leading one to the top, then shift right into the
  // subnormal range when the exponent falls below the smallest normal.
  always_comb begin
    lz = LW'(PW - 1);
    for (int i = 0; i < PW; i++) begin
      if (prod1_q[i]) lz = LW'(PW - 1 - i);
    end
    en     = {{(XW-EXP_W-2){exp1_q[EXP_W+1]}}, exp1_q} + XW'(1) - XW'(lz);
    nfr    = {prod1_q, 2'b00} << lz;
    sh     = '0;
    wide   = '0;
    sh_stk = 1'b0;
    if (en[XW-1] || (en == '0)) begin
      sh = XW'(1) - en;
      if (sh > XW'(FW)) sh = XW'(FW);
      wide   = {nfr, {FW{1'b0}}} >> sh;
      nfr    = wide[2*FW-1:FW];
      sh_stk = |wide[FW-1:0];
      en     = '0;
    end

    sign2_d   = sign2_q;
    zero2_d   = zero2_q;
    f2_d      = f2_q;
    kept2_d   = kept2_q;
    guard2_d  = guard2_q;
    sticky2_d = sticky2_q;
    if (ld2) begin
      sign2_d   = sign1_q;
      zero2_d   = (prod1_q == '0);
      f2_d      = en;
      kept2_d   = nfr[FW-1 -: MAN_W+1];
      guard2_d  = nfr[FW-2-MAN_W];
      sticky2_d = (|nfr[FW-3-MAN_W:0]) | sh_stk;
    end
  end

  logic             inc;
  logic [MAN_W+1:0] sum;
  logic [XW-1:0]    f;
  logic [MAN_W-1:0] man;

  // S3: a carry out of the mantissa, or a subnormal reaching the hidden
  // bit, bumps the exponent field by one.
  always_comb begin
    inc = guard2_q & (sticky2_q | kept2_q[0]);
    sum = {1'b0, kept2_q} + (MAN_W+2)'(inc);
    f   = f2_q + XW'(sum[MAN_W+1]) + XW'((f2_q == '0) & sum[MAN_W]);
    man = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];

    res3_d = res3_q;
    ovf3_d = ovf3_q;
    unf3_d = unf3_q;
    if (ld3) begin
      ovf3_d = 1'b0;
      unf3_d = 1'b0;
      if (zero2_q) begin
        res3_d = {sign2_q, {(W-1){1'b0}}};
      end else if (f > EMAX) begin
        res3_d = {sign2_q, {(W-1){1'b1}}};
        ovf3_d = 1'b1;
      end else begin
        res3_d = {sign2_q, f[EXP_W-1:0], man};
        unf3_d = (f == '0) && (man == '0);
      end
    end
  end

  // NOTE: only the visible output stage is reset; inner datapath registers
  // are don't-care until their stage valid bit (held in the top) is set.
  always_ff @(posedge clk) begin
    sign1_q   <= sign1_d;
    prod1_q   <= prod1_d;
    exp1_q    <= exp1_d;
    sign2_q   <= sign2_d;
    zero2_q   <= zero2_d;
    f2_q      <= f2_d;
    kept2_q   <= kept2_d;
    guard2_q  <= guard2_d;
    sticky2_q <= sticky2_d;
    if (!rst_n) begin
      res3_q <= '0;
      ovf3_q <= 1'b0;
      unf3_q <= 1'b0;
    end else begin
      res3_q <= res3_d;
      ovf3_q <= ovf3_d;
      unf3_q <= unf3_d;
    end
  end

  assign res = res3_q;
  assign ovf = ovf3_q;
  assign unf = unf3_q;

endmodule

// File: rtl/afp_mul_pipe.sv
// LANES-wide small-float multiplier with a 3-stage elastic pipeline;
// the top owns the shared valid/ready handshake and stage enables.
module afp_mul_pipe
  import afp_pkg::*;
#(
  parameter int  EXP_W = AFP_EXP_W,
  parameter int  MAN_W = AFP_MAN_W,
  parameter int  LANES = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] x,
  input  logic [LANES*W-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] result,
  output logic [LANES-1:0]   ovf,
  output logic [LANES-1:0]   unf
);

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic en1, en2, en3;
  logic ld1, ld2, ld3;

  // A stage can take new data when it is empty or its contents move on.
  always_comb begin
    en3      = ~v3_q | out_ready;
    en2      = ~v2_q | en3;
    en1      = ~v1_q | en2;
    in_ready = rst_n & en1;
    ld1      = in_valid & in_ready;
    ld2      = v1_q & en2;
    ld3      = v2_q & en3;
    v1_d     = en1 ? in_valid : v1_q;
    v2_d     = en2 ? v1_q : v2_q;
    v3_d     = en3 ? v2_q : v3_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  assign out_valid = v3_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    afp_mul_lane #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .ld1  (ld1),
      .ld2  (ld2),
      .ld3  (ld3),
      .a    (x[i*W +: W]),
      .b    (y[i*W +: W]),
      .res  (result[i*W +: W]),
      .ovf  (ovf[i]),
      .unf  (unf[i])
    );
  end

endmodule

// File: tb/tb_afp_mul_pipe.sv
// Scoreboard bench for afp_mul_pipe at default widths: directed lane
// products with hand-derived results, stall, and mid-flight reset.
module tb_afp_mul_pipe;

  localparam int LANES = 4;
  localparam int W     = 4;
  localparam int NE    = 18;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] x, y;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] result;
  logic [LANES-1:0]   ovf, unf;

  afp_mul_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  // Hand-computed single-lane products (values: 0001=0.5 .. 0111=6.0).
  logic [3:0] ta [NE] = '{4'b0000, 4'b0011, 4'b0101, 4'b1011, 4'b0001, 4'b1000,
                          4'b0010, 4'b0011, 4'b0001, 4'b0110, 4'b1001, 4'b0001,
                          4'b0111, 4'b0101, 4'b0111, 4'b1111, 4'b1001, 4'b0010};
  logic [3:0] tb [NE] = '{4'b0000, 4'b0011, 4'b0101, 4'b0100, 4'b0001, 4'b0010,
                          4'b0010, 4'b0100, 4'b0011, 4'b0110, 4'b1001, 4'b0010,
                          4'b0001, 4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0011};
  logic [3:0] tr [NE] = '{4'b0000, 4'b0100, 4'b0111, 4'b1101, 4'b0000, 4'b1000,
                          4'b0010, 4'b0101, 4'b0010, 4'b0111, 4'b0000, 4'b0001,
                          4'b0101, 4'b0110, 4'b0111, 4'b1111, 4'b1000, 4'b0011};
  logic       tov [NE] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
  logic       tun [NE] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

  typedef struct {
    logic [LANES*W-1:0] res;
    logic [LANES-1:0]   ovf;
    logic [LANES-1:0]   unf;
    int                 t_in;
    bit                 lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   saw_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int e0, input int e1, input int e2, input int e3, input bit lat);
    int   e[4];
    int   n;
    exp_t ex;
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < LANES; i++) begin
      x[i*W +: W]      = ta[e[i]];
      y[i*W +: W]      = tb[e[i]];
      ex.res[i*W +: W] = tr[e[i]];
      ex.ovf[i]        = tov[e[i]];
      ex.unf[i]        = tun[e[i]];
    end
    ex.lat   = lat;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      ex.t_in = cyc;
      sbq.push_back(ex);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented result to the queue head every valid
  // cycle (so a stalled result must hold), pops on the transfer.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (rst_n && !in_ready && in_valid) saw_stall = 1'b1;
      if (rst_n && out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          ex = sbq[0];
          if (!out_ready) begin
            check("hold_result", 32'(result), 32'(ex.res));
            check("hold_flags", 32'({ovf, unf}), 32'({ex.ovf, ex.unf}));
          end else begin
            check("result", 32'(result), 32'(ex.res));
            check("ovf", 32'(ovf), 32'(ex.ovf));
            check("unf", 32'(unf), 32'(ex.unf));
            if (ex.lat) check("latency", 32'(cyc - ex.t_in), 32'd3);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'({result, ovf, unf}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single-lane directed cases, streamed without stalls.
    send(1, 0, 0, 0, 1'b1);
    send(2, 0, 0, 0, 1'b1);
    send(3, 0, 0, 0, 1'b1);
    send(4, 0, 0, 0, 1'b1);
    send(5, 0, 0, 0, 1'b1);
    send(6, 7, 8, 9, 1'b1);
    send(10, 11, 12, 13, 1'b1);
    send(14, 15, 16, 17, 1'b1);
    wait_drain();

    // Eight back-to-back vectors with the consumer stalled for three cycles.
    saw_stall = 1'b0;
    fork
      begin
        send(1, 2, 3, 4, 1'b0);
        send(5, 6, 7, 8, 1'b0);
        send(9, 10, 11, 12, 1'b0);
        send(13, 14, 15, 16, 1'b0);
        send(17, 1, 2, 3, 1'b0);
        send(4, 5, 6, 7, 1'b0);
        send(8, 9, 10, 11, 1'b0);
        send(12, 13, 14, 15, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("in_ready_dropped", 32'(saw_stall), 32'd1);

    // Reset with three vectors in flight: all of them are discarded.
    send(1, 1, 1, 1, 1'b0);
    send(2, 2, 2, 2, 1'b0);
    send(3, 3, 3, 3, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", 32'({result, ovf, unf}), 32'd0);
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(13, 8, 4, 2, 1'b1);
    wait_drain();
    repeat (10) @(posedge clk);
    check("queue_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/afp_mul_pipe.md
AFP_MUL_PIPE -- requirements
Module: afp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 2, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 1, stored mantissa field width.
REQ-003 SHALL have parameter LANES, default 4, number of parallel multiply lanes.
REQ-004 SHALL derive W = 1+EXP_W+MAN_W (default 4) and BIAS = 2^(EXP_W-1)-1.
REQ-005 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 Port rst_n, input, 1: synchronous, active-low reset.
REQ-007 Port in_valid, input, 1: operand vectors valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts operands this cycle.
REQ-009 Port x, input, LANES*W: lane i operand A in bits [i*W +: W].
REQ-010 Port y, input, LANES*W: lane i operand B, same packing.
REQ-011 Port out_valid, output, 1: result vector valid.
REQ-012 Port out_ready, input, 1: consumer accepts result.
REQ-013 Port result, output, LANES*W: lane i product, same packing.
REQ-014 Port ovf, output, LANES: lane i result saturated.
REQ-015 Port unf, output, LANES: lane i nonzero exact product rounded to zero.

Function
REQ-016 Format: {sign, exp, man}; exp==0 is subnormal, value = 2^(1-BIAS)*0.man; otherwise value = 2^(exp-BIAS)*1.man; no Inf/NaN codes; all-ones exponent is normal.
REQ-017 Transfer occurs on a port when valid and ready are both high in the same cycle; only in_valid is sampled for acceptance.
REQ-018 Pipeline: S1 unpack + exact mantissa product (2*(MAN_W+1) bits) + exponent sum (EXP_W+2 bits, signed); S2 leading-zero count, normalize, sticky generation; S3 round-to-nearest-even, saturate, pack.
REQ-019 Latency: exactly 3 cycles from input transfer to out_valid, with no stalls; throughput one vector per cycle.
REQ-020 in_ready = ~S3_valid | out_ready | ~(all stages valid); each stage advances when its successor is empty or advancing; no bubble insertion while out_ready stays high.
REQ-021 While out_valid=1 and out_ready=0, result, ovf and unf SHALL hold stable.
REQ-022 Result sign = xA sign XOR yB sign, including zero results (signed zero preserved).
REQ-023 Product magnitude above max finite value after rounding -> max finite magnitude (exp all-ones, man all-ones), ovf=1.
REQ-024 Nonzero exact product that rounds to zero magnitude -> signed zero, unf=1; exact zero operand -> zero, unf=0.
REQ-025 Subnormal results SHALL be produced (gradual underflow); rounding carry out of subnormal/mantissa range increments exponent.
REQ-026 Lanes are independent in arithmetic and share one valid/ready handshake.

Reset
REQ-027 rst_n low at a rising edge clears all stage valid bits; out_valid=0, result=0, ovf=0, unf=0 the following cycle.
REQ-028 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-029 Reset mid-operation discards all in-flight vectors; none emerge after release.

Structure
REQ-030 Package afp_pkg SHALL hold EXP_W/MAN_W defaults, BIAS function, and the unpacked-operand struct {sign, signed exponent, mantissa with hidden bit}.
REQ-031 Sub-module afp_mul_lane SHALL hold one lane's S1-S3 datapath registers, enabled by stage-advance signals from afp_mul_pipe; the top instantiates LANES copies and owns the handshake.

Verification (defaults, lane 0 shown; other lanes 0000)
REQ-032 x=0011 (1.5), y=0011 -> 2.25 rounds to 0100 (2.0), ovf=0, unf=0, out_valid exactly 3 cycles after transfer.
REQ-033 x=0101 (3.0), y=0101 -> 9.0 saturates to 0111 (6.0), ovf=1; x=1011 (-1.5), y=0100 -> 1101 (-3.0).
REQ-034 x=0001 (0.5), y=0001 -> 0.25 ties to even 0000, unf=1; x=1000, y=0010 -> 1000 (-0), unf=0.
REQ-035 Back-to-back 8 vectors, out_ready low cycles 4-6 -> in_ready drops once pipeline full, outputs held stable, all 8 results in order, none lost or duplicated.
REQ-036 rst_n low for one cycle with 3 vectors in flight -> out_valid=0 next cycle, no stale result after release, first new vector returns after 3 cycles.
